serial_word_tx: RTL and testbench

- Parallel-to-serial framed transmitter. It is the sending end of the bit-serial link consumed by the 4-bit SIPO receiver (shift_in / clken / out).
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Shifts each word out MSB-first, one bit per clken strobe, with no gap between back-to-back words.
- Drives shift_valid so the receiver's clken is formed as (clken & shift_valid); the receiver's out then equals the sent word after WIDTH strobes.

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/serial_word_tx.sv | 99 +++++++++
 tb/tb_serial_word_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Types and constants shared by both ends of the bit-serial link.
// Also holds the word width the transmitter and the SIPO receiver agree on.
package serial_link_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  // Words travel most-significant bit first.
  localparam bit MSB_FIRST = 1'b1;

  localparam int LINK_WIDTH = 4;

endpackage

// File: rtl/serial_word_tx.sv
// Framed parallel-to-serial transmitter: one buffered word behind the shifter,
// MSB-first, one bit per clken strobe, back-to-back words with no gap.
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clken,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  assign in_ready    = !hold_full_q && !reset;
  assign shift_valid = (state_q == SHIFT);
  assign shift_out   = shift_valid ? shreg_q[WIDTH-1] : 1'b0;
  assign busy        = (state_q == SHIFT) || hold_full_q;
  assign done        = done_q;

  // in_ready needs an empty holding register, so an accept can never collide
  // with the same-edge transfer of the held word into the shifter.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_reg_d  = hold_reg_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;

    if (in_valid && in_ready) begin
      hold_reg_d  = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shreg_d     = hold_reg_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (clken) begin
          if (bit_cnt_q == LAST_BIT) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              shreg_d     = hold_reg_q;
              hold_full_d = 1'b0;
              bit_cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_reg_q  <= hold_reg_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: a scoreboard of expected bits/words feeds a SIPO
// loopback model, plus a reset/first-word vector table and multi-cycle sequences.
module tb_serial_word_tx;
  import serial_link_pkg::*;

  localparam int W = LINK_WIDTH;

  logic         clk;
  logic         reset;
  logic [W-1:0] inData;
  logic         inValid;
  logic         inReady;
  logic         clken;
  logic         shiftOut;
  logic         shiftValid;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic         expBitQ[$];
  logic [W-1:0] expWordQ[$];
  logic [W-1:0] sipo;

  logic [W-1:0] txWords[4];
  int           accCyc[4];
  int           doneCyc[4];

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] data;
    logic         ce;
    logic         eReady;
    logic         eValid;
    logic         eBusy;
    logic         eDone;
    logic         eOut;
  } vec_t;

  vec_t vecs[9];

  serial_word_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (inData),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .clken      (clken),
    .shift_out  (shiftOut),
    .shift_valid(shiftValid),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [W-1:0] data,
                               input logic ce);
    @(posedge clk);
    #1;
    reset   = rst;
    inValid = vld;
    inData  = data;
    clken   = ce;
  endtask

  task automatic checkOutput(input int idx);
    @(negedge clk);
    checkVal($sformatf("vec%0d_in_ready", idx), 32'(inReady), 32'(vecs[idx].eReady));
    checkVal($sformatf("vec%0d_shift_valid", idx), 32'(shiftValid), 32'(vecs[idx].eValid));
    checkVal($sformatf("vec%0d_busy", idx), 32'(busy), 32'(vecs[idx].eBusy));
    checkVal($sformatf("vec%0d_done", idx), 32'(done), 32'(vecs[idx].eDone));
    checkVal($sformatf("vec%0d_shift_out", idx), 32'(shiftOut), 32'(vecs[idx].eOut));
  endtask

  // Scoreboard: words are queued when the handshake fires, bits are checked
  // as each strobe consumes them, and the SIPO model is checked on done.
  always @(negedge clk) begin
    if (reset) begin
      expBitQ.delete();
      expWordQ.delete();
      sipo = '0;
    end else begin
      if (done) begin
        if (expWordQ.size() == 0) begin
          checkVal("done_spurious", 32'd1, 32'd0);
        end else begin
          checkVal("sipo_loopback", 32'(sipo), 32'(expWordQ.pop_front()));
        end
      end
      if (shiftValid && clken) begin
        if (expBitQ.size() == 0) begin
          checkVal("bit_unexpected", 32'd1, 32'd0);
        end else begin
          checkVal("serial_bit", 32'(shiftOut), 32'(expBitQ.pop_front()));
        end
        sipo = {sipo[W-2:0], shiftOut};
      end
      if (inValid && inReady) begin
        expWordQ.push_back(inData);
        for (int i = W - 1; i >= 0; i--) expBitQ.push_back(inData[i]);
      end
    end
  end

  // Offers txWords[0..n-1] in order, holding each until accepted; clken
  // strobes once every `period` cycles. Records accept and done cycles.
  task automatic sendWords(input int n, input int period, input int budget);
    int   sent = 0;
    int   doneCnt = 0;
    int   cyc = 0;
    bit   svSeen = 0;
    logic prevSv = 0;
    logic prevCe = 0;
    logic prevOut = 0;
    logic ce;
    while (doneCnt < n && cyc < budget) begin
      ce = (period <= 1) ? 1'b1 : ((cyc % period) == (period - 1));
      applyStimulus(1'b0, sent < n, txWords[(sent < n) ? sent : 0], ce);
      @(negedge clk);
      if (done) begin
        doneCyc[doneCnt] = cyc;
        doneCnt++;
      end
      if (svSeen && doneCnt < n) checkVal("sv_contiguous", 32'(shiftValid), 32'd1);
      if (prevSv && !prevCe && shiftValid) checkVal("bit_stable", 32'(shiftOut), 32'(prevOut));
      if (shiftValid) svSeen = 1;
      if (inValid && inReady) begin
        accCyc[sent] = cyc;
        sent++;
      end
      prevSv  = shiftValid;
      prevCe  = clken;
      prevOut = shiftOut;
      cyc++;
    end
    if (doneCnt < n) checkVal("send_timeout", 32'(doneCnt), 32'(n));
  endtask

  initial begin
    reset   = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    clken   = 1'b0;

    //           rst   vld   data     ce    rdy   sv    busy  done  out
    vecs[0] = '{1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    $display("[TB] reset and single word 1011");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].ce);
      checkOutput(i);
    end

    $display("[TB] sparse strobe, word 0110");
    txWords[0] = 4'b0110;
    sendWords(1, 3, 60);

    $display("[TB] back-to-back A then 5");
    txWords[0] = 4'hA;
    txWords[1] = 4'h5;
    sendWords(2, 1, 40);
    checkVal("b2b_done_spacing", 32'(doneCyc[1] - doneCyc[0]), 32'd4);

    $display("[TB] backpressure, three words");
    txWords[0] = 4'h9;
    txWords[1] = 4'hC;
    txWords[2] = 4'h3;
    sendWords(3, 1, 60);
    checkVal("bp_accept0", 32'(accCyc[0]), 32'd0);
    checkVal("bp_accept1", 32'(accCyc[1]), 32'd2);
    checkVal("bp_done0", 32'(doneCyc[0]), 32'd6);
    checkVal("bp_accept2", 32'(accCyc[2]), 32'(doneCyc[0]));
    checkVal("bp_done_spacing", 32'(doneCyc[2] - doneCyc[1]), 32'd4);

    $display("[TB] mid-frame reset during 1100");
    applyStimulus(1'b0, 1'b1, 4'b1100, 1'b1);
    @(negedge clk);
    checkVal("mr_accept_ready", 32'(inReady), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    checkVal("mr_hold_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    checkVal("mr_bit3", 32'(shiftOut), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    checkVal("mr_bit2", 32'(shiftOut), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    checkVal("mr_ready_in_reset", 32'(inReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    checkVal("mr_shift_valid", 32'(shiftValid), 32'd0);
    checkVal("mr_busy", 32'(busy), 32'd0);
    checkVal("mr_done", 32'(done), 32'd0);
    checkVal("mr_shift_out", 32'(shiftOut), 32'd0);
    checkVal("mr_ready_after", 32'(inReady), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    checkVal("mr_no_done", 32'(done), 32'd0);
    txWords[0] = 4'b0011;
    sendWords(1, 1, 30);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      @(negedge clk);
    end
    checkVal("final_idle_busy", 32'(busy), 32'd0);
    checkVal("sb_bits_left", 32'(expBitQ.size()), 32'd0);
    checkVal("sb_words_left", 32'(expWordQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
